// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scan controller with two display banks.
// Loads are staged in a holding register and committed only at frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned SWAP_FRAMES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] data,
  input  logic        bank_sel,
  input  logic        blank,
  output logic        load_ack,
  output logic [6:0]  CA,
  output logic [7:0]  AN,
  output logic [1:0]  digit,
  output logic        phase
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FW = (SWAP_FRAMES > 1) ? $clog2(SWAP_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(SWAP_FRAMES - 1);

  typedef enum logic {S_IDLE, S_PEND} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;
  logic [15:0]   hold_data_q, hold_data_d;
  logic          hold_bank_q, hold_bank_d;
  logic [15:0]   bank0_q, bank0_d;
  logic [15:0]   bank1_q, bank1_d;
  logic          ack_q, ack_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    ca_q, ca_d;

  logic          scan_tick_c;
  logic          frame_end_c;
  logic [15:0]   cur_bank_c;
  logic [3:0]    nib_c;

  // Active-low hex decode, segment a in bit 6.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'b0000001;
      4'h1:    hex7 = 7'b1001111;
      4'h2:    hex7 = 7'b0010010;
      4'h3:    hex7 = 7'b0000110;
      4'h4:    hex7 = 7'b1001100;
      4'h5:    hex7 = 7'b0100100;
      4'h6:    hex7 = 7'b0100000;
      4'h7:    hex7 = 7'b0001111;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0000100;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b1100000;
      4'hC:    hex7 = 7'b0110001;
      4'hD:    hex7 = 7'b1000010;
      4'hE:    hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q + PW'(1);
    digit_d     = digit_q;
    frame_d     = frame_q;
    phase_d     = phase_q;
    hold_data_d = hold_data_q;
    hold_bank_d = hold_bank_q;
    bank0_d     = bank0_q;
    bank1_d     = bank1_q;
    ack_d       = 1'b0;

    scan_tick_c = (presc_q == PRESC_MAX);
    frame_end_c = scan_tick_c && (digit_q == 2'd3);

    if (scan_tick_c) begin
      presc_d = '0;
      digit_d = digit_q + 2'd1;
    end

    if (frame_end_c) begin
      if (frame_q == FRAME_MAX) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (load) begin
          hold_data_d = data;
          hold_bank_d = bank_sel;
          state_d     = S_PEND;
        end
      end
      S_PEND: begin
        // Commit only at a frame boundary so the visible bank never tears.
        if (frame_end_c) begin
          if (hold_bank_q) bank1_d = hold_data_q;
          else             bank0_d = hold_data_q;
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cur_bank_c = phase_q ? bank1_q : bank0_q;
    nib_c      = cur_bank_c[{digit_q, 2'b00} +: 4];
    if (blank) begin
      an_d = 8'hFF;
      ca_d = 7'h7F;
    end else begin
      an_d = {4'hF, ~(4'b0001 << digit_q)};
      ca_d = hex7(nib_c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      digit_q     <= '0;
      frame_q     <= '0;
      phase_q     <= 1'b0;
      hold_data_q <= '0;
      hold_bank_q <= 1'b0;
      bank0_q     <= '0;
      bank1_q     <= '0;
      ack_q       <= 1'b0;
      an_q        <= 8'hFF;
      ca_q        <= 7'h7F;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      digit_q     <= digit_d;
      frame_q     <= frame_d;
      phase_q     <= phase_d;
      hold_data_q <= hold_data_d;
      hold_bank_q <= hold_bank_d;
      bank0_q     <= bank0_d;
      bank1_q     <= bank1_d;
      ack_q       <= ack_d;
      an_q        <= an_d;
      ca_q        <= ca_d;
    end
  end

  assign load_ack = ack_q;
  assign CA       = ca_q;
  assign AN       = an_q;
  assign digit    = digit_q;
  assign phase    = phase_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=2, SWAP_FRAMES=2.
// cyc counts rising edges since reset release; frames end every 8 edges, phase flips every 16.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] data;
  logic        bank_sel;
  logic        blank;
  logic        load_ack;
  logic [6:0]  CA;
  logic [7:0]  AN;
  logic [1:0]  digit;
  logic        phase;

  int checks;
  int errors;
  int cyc;
  logic [7:0] an_tab [4];

  seg_scan_ctrl #(.SCAN_DIV(2), .SWAP_FRAMES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data     (data),
    .bank_sel (bank_sel),
    .blank    (blank),
    .load_ack (load_ack),
    .CA       (CA),
    .AN       (AN),
    .digit    (digit),
    .phase    (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc != n) begin errors++; $display("FAIL wait_cyc got %0d exp %0d", cyc, n); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL reset_an got %h exp ff", AN); end
    checks++; if (CA !== 7'h7F) begin errors++; $display("FAIL reset_ca got %b exp 1111111", CA); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", load_ack); end
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL reset_phase got %b exp 0", phase); end
    checks++; if (digit !== 2'd0) begin errors++; $display("FAIL reset_digit got %0d exp 0", digit); end
    reset = 1'b0;
    wait_cyc(1);
    checks++; if (AN !== 8'hFE) begin errors++; $display("FAIL release_an got %h exp fe", AN); end
    checks++; if (CA !== 7'b0000001) begin errors++; $display("FAIL release_ca got %b exp 0000001", CA); end
  endtask

  task automatic test_scan();
    logic [7:0] exp_an;
    logic [1:0] exp_dig;
    for (int c = 1; c <= 10; c++) begin
      wait_cyc(c);
      exp_an  = an_tab[((c - 1) / 2) % 4];
      exp_dig = 2'((c / 2) % 4);
      checks++; if (AN !== exp_an) begin errors++; $display("FAIL scan_an cyc %0d got %h exp %h", c, AN, exp_an); end
      checks++; if (digit !== exp_dig) begin errors++; $display("FAIL scan_digit cyc %0d got %0d exp %0d", c, digit, exp_dig); end
    end
  endtask

  task automatic test_phase();
    wait_cyc(15);
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL phase_c15 got %b exp 0", phase); end
    wait_cyc(16);
    checks++; if (phase !== 1'b1) begin errors++; $display("FAIL phase_c16 got %b exp 1", phase); end
    wait_cyc(17);
    checks++; if (AN !== 8'hFE) begin errors++; $display("FAIL phase_an_c17 got %h exp fe", AN); end
    checks++; if (CA !== 7'b0000001) begin errors++; $display("FAIL phase_ca_c17 got %b exp 0000001", CA); end
    wait_cyc(32);
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL phase_c32 got %b exp 0", phase); end
  endtask

  task automatic test_load();
    logic exp_ack;
    wait_cyc(34);
    load = 1'b1; bank_sel = 1'b0; data = 16'h4321;
    wait_cyc(35);
    load = 1'b0; data = 16'h0000;
    for (int c = 35; c <= 41; c++) begin
      wait_cyc(c);
      exp_ack = (c == 40);
      checks++; if (load_ack !== exp_ack) begin errors++; $display("FAIL load_ack cyc %0d got %b exp %b", c, load_ack, exp_ack); end
    end
    checks++; if (CA !== 7'b1001111) begin errors++; $display("FAIL load_d0 got %b exp 1001111", CA); end
    wait_cyc(43);
    checks++; if (CA !== 7'b0010010) begin errors++; $display("FAIL load_d1 got %b exp 0010010", CA); end
    wait_cyc(45);
    checks++; if (CA !== 7'b0000110) begin errors++; $display("FAIL load_d2 got %b exp 0000110", CA); end
    wait_cyc(47);
    checks++; if (CA !== 7'b1001100) begin errors++; $display("FAIL load_d3 got %b exp 1001100", CA); end
    checks++; if (AN !== 8'hF7) begin errors++; $display("FAIL load_an3 got %h exp f7", AN); end
  endtask

  task automatic test_phase_commit();
    wait_cyc(74);
    load = 1'b1; bank_sel = 1'b1; data = 16'h8765;
    wait_cyc(75);
    load = 1'b0; data = 16'h0000; bank_sel = 1'b0;
    wait_cyc(79);
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL pc_phase_c79 got %b exp 0", phase); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL pc_ack_c79 got %b exp 0", load_ack); end
    wait_cyc(80);
    checks++; if (phase !== 1'b1) begin errors++; $display("FAIL pc_phase_c80 got %b exp 1", phase); end
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL pc_ack_c80 got %b exp 1", load_ack); end
    wait_cyc(81);
    checks++; if (CA !== 7'b0100100) begin errors++; $display("FAIL pc_d0 got %b exp 0100100", CA); end
    checks++; if (AN !== 8'hFE) begin errors++; $display("FAIL pc_an0 got %h exp fe", AN); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL pc_ack_c81 got %b exp 0", load_ack); end
    wait_cyc(83);
    checks++; if (CA !== 7'b0100000) begin errors++; $display("FAIL pc_d1 got %b exp 0100000", CA); end
    wait_cyc(85);
    checks++; if (CA !== 7'b0001111) begin errors++; $display("FAIL pc_d2 got %b exp 0001111", CA); end
    wait_cyc(87);
    checks++; if (CA !== 7'b0000000) begin errors++; $display("FAIL pc_d3 got %b exp 0000000", CA); end
  endtask

  task automatic test_ignored_load();
    int acks;
    acks = 0;
    wait_cyc(98);
    load = 1'b1; bank_sel = 1'b0; data = 16'hFEDC;
    for (int c = 99; c <= 111; c++) begin
      wait_cyc(c);
      if (c == 99) begin bank_sel = 1'b1; data = 16'h0000; end
      if (c == 101) load = 1'b0;
      if (load_ack === 1'b1) acks++;
      if (c == 104) begin
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL ign_ack_c104 got %b exp 1", load_ack); end
      end
      if (c == 105) begin
        checks++; if (CA !== 7'b0110001) begin errors++; $display("FAIL ign_d0 got %b exp 0110001", CA); end
      end
      if (c == 107) begin
        checks++; if (CA !== 7'b1000010) begin errors++; $display("FAIL ign_d1 got %b exp 1000010", CA); end
      end
      if (c == 109) begin
        checks++; if (CA !== 7'b0110000) begin errors++; $display("FAIL ign_d2 got %b exp 0110000", CA); end
      end
      if (c == 111) begin
        checks++; if (CA !== 7'b0111000) begin errors++; $display("FAIL ign_d3 got %b exp 0111000", CA); end
      end
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL ign_ack_count got %0d exp 1", acks); end
    wait_cyc(113);
    checks++; if (CA !== 7'b0100100) begin errors++; $display("FAIL ign_bank1_d0 got %b exp 0100100", CA); end
  endtask

  task automatic test_blank();
    logic [1:0] exp_dig;
    wait_cyc(114);
    blank = 1'b1;
    for (int c = 115; c <= 118; c++) begin
      wait_cyc(c);
      exp_dig = 2'((c / 2) % 4);
      checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL blank_an cyc %0d got %h exp ff", c, AN); end
      checks++; if (CA !== 7'h7F) begin errors++; $display("FAIL blank_ca cyc %0d got %b exp 1111111", c, CA); end
      checks++; if (digit !== exp_dig) begin errors++; $display("FAIL blank_digit cyc %0d got %0d exp %0d", c, digit, exp_dig); end
    end
    blank = 1'b0;
    wait_cyc(119);
    checks++; if (AN !== 8'hF7) begin errors++; $display("FAIL unblank_an got %h exp f7", AN); end
    checks++; if (CA !== 7'b0000000) begin errors++; $display("FAIL unblank_ca got %b exp 0000000", CA); end
  endtask

  task automatic test_reset_pend();
    int acks;
    acks = 0;
    wait_cyc(120);
    load = 1'b1; bank_sel = 1'b0; data = 16'h1234;
    wait_cyc(121);
    load = 1'b0; data = 16'h0000;
    wait_cyc(122);
    reset = 1'b1;
    #1;
    checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL rp_an got %h exp ff", AN); end
    checks++; if (CA !== 7'h7F) begin errors++; $display("FAIL rp_ca got %b exp 1111111", CA); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL rp_ack got %b exp 0", load_ack); end
    checks++; if (digit !== 2'd0) begin errors++; $display("FAIL rp_digit got %0d exp 0", digit); end
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL rp_phase got %b exp 0", phase); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      wait_cyc(c);
      if (load_ack === 1'b1) acks++;
      checks++; if (CA !== 7'b0000001) begin errors++; $display("FAIL rp_ca cyc %0d got %b exp 0000001", c, CA); end
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL rp_ack_count got %0d exp 0", acks); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    load     = 1'b0;
    data     = 16'h0000;
    bank_sel = 1'b0;
    blank    = 1'b0;
    an_tab[0] = 8'hFE;
    an_tab[1] = 8'hFD;
    an_tab[2] = 8'hFB;
    an_tab[3] = 8'hF7;

    test_reset();
    test_scan();
    test_phase();
    test_load();
    test_phase_commit();
    test_ignored_load();
    test_blank();
    test_reset_pend();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
